saxi_integrate_dump: RTL and testbench
======================================

# saxi_integrate_dump

Integrate-and-dump decimator for the 32-bit AXI-stream sample path. It accepts signed 32-bit samples, sums each block of N consecutive accepted samples, scales the sum by an arithmetic right shift, and emits one 32-bit result per block. It sits directly downstream of the stall-prone passthrough stage and consumes its output stream. It applies full AXI-stream backpressure on both sides.

## Interface
- N, default 4: decimation factor, samples per block; legal range 2..256.
- SHIFT, default 2: arithmetic right shift applied to the block sum before output; legal range 0..(clog2(N)+8).
- ACLK  input  1  clock; all logic on the rising edge.
- ARESETn  input  1  reset; synchronous, active-low.
- TREADY_IN  output  1  upstream ready.
- TVALID_IN  input  1  upstream valid.
- TDATA_IN  input  32  upstream sample, two's complement.
- TREADY_OUT  input  1  downstream ready.
- TVALID_OUT  output  1  result valid.
- TDATA_OUT  output  32  scaled block sum, two's complement.

## Operation
- Input accept: TVALID_IN && TREADY_IN at a rising edge. Output transfer: TVALID_OUT && TREADY_OUT at a rising edge.
- Accumulator: signed, width 32+clog2(N); sample count `cnt` runs 0..N-1.
- On an accept with cnt < N-1: acc += sign-extended TDATA_IN; cnt++.
- On an accept with cnt == N-1 (dump):
  - result = (acc + sample) >>> SHIFT, then reduced to 32 bits (see Configuration);
  - the result is loaded into the output register and TVALID_OUT <= 1;
  - acc <= 0 and cnt <= 0 in the same cycle, so there is no dead cycle between blocks.
- Output register clear: TVALID_OUT <= 0 on an output transfer, unless a dump occurs in the same cycle. A dump has priority and reloads the register.
- TREADY_IN = !(cnt == N-1 && TVALID_OUT && !TREADY_OUT).
  - Only a dump can be blocked; non-final samples are always accepted.
  - TREADY_IN is combinational from TREADY_OUT; this is the only comb path.
- TDATA_OUT must stay stable while TVALID_OUT && !TREADY_OUT.
- States are implicit: ACCUM (cnt < N-1), LAST (cnt == N-1). Output holding is tracked separately by TVALID_OUT.

## Timing
- Reset (ARESETn low at a clock edge): acc=0, cnt=0, TVALID_OUT=0, TDATA_OUT=0.
  - TREADY_IN is 1 during and after reset.
- Reset mid-block discards the partial sum. Reset while TVALID_OUT=1 drops the pending result.
- Latency: the result is valid on the first edge after the Nth accept.
- Throughput: 1 sample per cycle sustained when TREADY_OUT=1.
- Simultaneous dump and output transfer: the old result transfers, the new one loads, and TVALID_OUT stays 1.
- With TREADY_OUT held at 0: at most N-1 further samples are absorbed after a result, then TREADY_IN falls.
- cnt wraps N-1 -> 0 only on a dump.

## Configuration
- SAXI_ID_SAT_EN defined: the shifted sum saturates to 32-bit signed range.
  - Above 0x7FFFFFFF outputs 0x7FFFFFFF; below 0x80000000 outputs 0x80000000.
- SAXI_ID_SAT_EN undefined: the shifted sum is truncated to its low 32 bits (wrap-around).
- Handshake and timing are identical in both builds.

## Structure
- Shared package saxi_pkg:
  - DATA_W = 32;
  - SAT_MAX / SAT_MIN constants;
  - acc_width function (32+clog2(N)).
- Sub-module saxi_sat: combinational; wide signed input, 32-bit output.
  - Performs saturate or truncate depending on SAXI_ID_SAT_EN.
  - Instantiated once on the dump path.

## Test plan
- Reset check: hold ARESETn=0 for 3 cycles with TVALID_IN=1 -> TVALID_OUT=0, TDATA_OUT=0, TREADY_IN=1, and no accept is counted after release.
- Basic dump: N=4, SHIFT=2, TREADY_OUT=1; samples 4, 8, 12, 16 back-to-back -> a single TDATA_OUT=10 one cycle after the 4th accept. Then samples 1, 1, 1, 1 -> TDATA_OUT=1, with no gap between blocks.
- Negative rounding: N=4, SHIFT=2; samples -1, -1, -1, -2 -> TDATA_OUT=0xFFFFFFFE (-5>>>2 = -2).
- Backpressure: TREADY_OUT=0 after the first result; feed 5 more samples.
  - The first 3 are accepted.
  - TREADY_IN=0 with cnt=3 until TREADY_OUT=1.
  - The first result is held stable throughout.
  - On release, the old result transfers and the new result loads the same cycle.
- Saturation: N=2, SHIFT=0; samples 0x7FFFFFFF, 0x7FFFFFFF -> 0x7FFFFFFF with SAXI_ID_SAT_EN, 0xFFFFFFFE without. Samples 0x80000000 twice -> 0x80000000 with, 0x00000000 without.
- Mid-block reset: accept 2 of 4 samples (100, 100), pulse ARESETn low 1 cycle, then send 1, 2, 3, 6 -> TDATA_OUT=3 (N=4, SHIFT=2); the partial sum is discarded.

Source files
------------

// File: rtl/saxi_pkg.sv
// Shared definitions for the saxi_* 32-bit AXI-stream sample path blocks.
package saxi_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  // Block phase of the integrate-and-dump counter
  typedef enum logic {
    PH_ACCUM = 1'b0,
    PH_LAST  = 1'b1
  } phase_e;

  // Accumulator width able to hold the sum of n full-scale signed samples
  function automatic int acc_width(input int n);
    return DATA_W + $clog2(n);
  endfunction

endpackage

// File: rtl/saxi_sat.sv
// Reduces a wide signed block sum to a 32-bit sample.
// Build option SAXI_ID_SAT_EN: defined -> saturate to the signed 32-bit range,
// undefined -> keep the low 32 bits (two's complement wrap-around).
module saxi_sat
  import saxi_pkg::*;
#(
  parameter int IN_W = 34
) (
  input  logic signed [IN_W-1:0]   wide_sum_s,
  output logic        [DATA_W-1:0] result_s
);

`ifdef SAXI_ID_SAT_EN
  logic [IN_W-DATA_W:0] upper_s;

  // Clamp whenever the bits above the 32-bit sign bit disagree with it
  always_comb begin
    upper_s = wide_sum_s[IN_W-1:DATA_W-1];
    if ((&upper_s) || !(|upper_s)) begin
      result_s = wide_sum_s[DATA_W-1:0];
    end else if (wide_sum_s[IN_W-1]) begin
      result_s = SAT_MIN;
    end else begin
      result_s = SAT_MAX;
    end
  end
`else
  logic unused_hi_s;

  // Upper bits are intentionally discarded in the wrap-around build
  always_comb begin
    unused_hi_s = ^wide_sum_s[IN_W-1:DATA_W];
  end

  // Plain truncation to the low 32 bits
  always_comb begin
    result_s = wide_sum_s[DATA_W-1:0];
  end
`endif

endmodule

// File: rtl/saxi_integrate_dump.sv
// Integrate-and-dump decimator: sums each block of N accepted signed samples,
// arithmetic-shifts the sum right by SHIFT and emits one result per block.
// Build option SAXI_ID_SAT_EN selects saturation (defined) or wrap-around
// (undefined) when reducing the scaled sum to 32 bits; handshake is identical.
module saxi_integrate_dump
  import saxi_pkg::*;
#(
  parameter int N     = 4,
  parameter int SHIFT = 2
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  output logic              TREADY_IN,
  input  logic              TVALID_IN,
  input  logic [DATA_W-1:0] TDATA_IN,
  input  logic              TREADY_OUT,
  output logic              TVALID_OUT,
  output logic [DATA_W-1:0] TDATA_OUT
);

  localparam int ACC_W = acc_width(N);
  localparam int CNT_W = $clog2(N);

  localparam logic signed [ACC_W-1:0] ACC_ZERO = {ACC_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N-1);

  logic signed [ACC_W-1:0]  acc_r;
  logic signed [ACC_W-1:0]  acc_nxt_s;
  logic signed [ACC_W-1:0]  sample_ext_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  shifted_s;
  logic        [CNT_W-1:0]  cnt_r;
  logic        [CNT_W-1:0]  cnt_nxt_s;
  logic                     tvalid_r;
  logic                     tvalid_nxt_s;
  logic        [DATA_W-1:0] tdata_r;
  logic        [DATA_W-1:0] tdata_nxt_s;
  logic        [DATA_W-1:0] dump_val_s;
  phase_e                   phase_s;
  logic                     tready_in_s;
  logic                     accept_s;
  logic                     xfer_s;
  logic                     dump_s;

  // Decode the implicit block phase from the sample count
  always_comb begin
    if (cnt_r == CNT_LAST) begin
      phase_s = PH_LAST;
    end else begin
      phase_s = PH_ACCUM;
    end
  end

  // Handshake: only the block-final sample can stall, and only while a result waits
  always_comb begin
    tready_in_s = !((phase_s == PH_LAST) && tvalid_r && !TREADY_OUT);
    accept_s    = TVALID_IN && tready_in_s;
    xfer_s      = tvalid_r && TREADY_OUT;
    dump_s      = accept_s && (phase_s == PH_LAST);
  end

  // Running sum including the incoming sample, scaled for the dump path
  always_comb begin
    sample_ext_s = {{(ACC_W-DATA_W){TDATA_IN[DATA_W-1]}}, TDATA_IN};
    sum_s        = acc_r + sample_ext_s;
    shifted_s    = sum_s >>> SHIFT;
  end

  saxi_sat #(
    .IN_W (ACC_W)
  ) u_sat (
    .wide_sum_s (shifted_s),
    .result_s   (dump_val_s)
  );

  // Next-state: accumulate or dump; a dump reloads the output even during a transfer
  always_comb begin
    acc_nxt_s    = acc_r;
    cnt_nxt_s    = cnt_r;
    tvalid_nxt_s = tvalid_r;
    tdata_nxt_s  = tdata_r;
    if (accept_s) begin
      case (phase_s)
        PH_ACCUM: begin
          acc_nxt_s = sum_s;
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
        PH_LAST: begin
          acc_nxt_s = ACC_ZERO;
          cnt_nxt_s = CNT_ZERO;
        end
        default: begin
          acc_nxt_s = ACC_ZERO;
          cnt_nxt_s = CNT_ZERO;
        end
      endcase
    end else begin
      acc_nxt_s = acc_r;
      cnt_nxt_s = cnt_r;
    end
    if (dump_s) begin
      tvalid_nxt_s = 1'b1;
      tdata_nxt_s  = dump_val_s;
    end else if (xfer_s) begin
      tvalid_nxt_s = 1'b0;
      tdata_nxt_s  = tdata_r;
    end else begin
      tvalid_nxt_s = tvalid_r;
      tdata_nxt_s  = tdata_r;
    end
  end

  // State registers; reset drops any partial block and pending result
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      acc_r    <= ACC_ZERO;
      cnt_r    <= CNT_ZERO;
      tvalid_r <= 1'b0;
      tdata_r  <= {DATA_W{1'b0}};
    end else begin
      acc_r    <= acc_nxt_s;
      cnt_r    <= cnt_nxt_s;
      tvalid_r <= tvalid_nxt_s;
      tdata_r  <= tdata_nxt_s;
    end
  end

  assign TREADY_IN  = tready_in_s;
  assign TVALID_OUT = tvalid_r;
  assign TDATA_OUT  = tdata_r;

endmodule

// File: tb/tb_saxi_integrate_dump.sv
// Self-checking bench for saxi_integrate_dump (N=4, SHIFT=2 main instance,
// N=2, SHIFT=0 instance for the 32-bit reduction corner cases).
module tb_saxi_integrate_dump;

  localparam int N     = 4;
  localparam int SHIFT = 2;
  localparam longint MAXV = 64'sh7FFF_FFFF;
  localparam longint MINV = -64'sh8000_0000;

  logic        aclk;
  logic        aresetn;
  logic        tready_in;
  logic        tvalid_in;
  logic [31:0] tdata_in;
  logic        tready_out;
  logic        tvalid_out;
  logic [31:0] tdata_out;

  logic        tready_in2;
  logic        tvalid_in2;
  logic [31:0] tdata_in2;
  logic        tvalid_out2;
  logic [31:0] tdata_out2;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int cyc      = 0;

  // model state: samples in the current block and results not yet delivered
  int          blk_n;
  longint      blk_sum;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  bit          live = 1'b0;

  saxi_integrate_dump #(.N(N), .SHIFT(SHIFT)) dut (
    .ACLK       (aclk),
    .ARESETn    (aresetn),
    .TREADY_IN  (tready_in),
    .TVALID_IN  (tvalid_in),
    .TDATA_IN   (tdata_in),
    .TREADY_OUT (tready_out),
    .TVALID_OUT (tvalid_out),
    .TDATA_OUT  (tdata_out)
  );

  saxi_integrate_dump #(.N(2), .SHIFT(0)) dut2 (
    .ACLK       (aclk),
    .ARESETn    (aresetn),
    .TREADY_IN  (tready_in2),
    .TVALID_IN  (tvalid_in2),
    .TDATA_IN   (tdata_in2),
    .TREADY_OUT (1'b1),
    .TVALID_OUT (tvalid_out2),
    .TDATA_OUT  (tdata_out2)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
  endtask

  // scaled block sum reduced to 32 bits, straight from the arithmetic definition
  function automatic logic [31:0] ref_scale(input longint s);
    longint sh;
    sh = s >>> SHIFT;
`ifdef SAXI_ID_SAT_EN
    if (sh > MAXV) sh = MAXV;
    else if (sh < MINV) sh = MINV;
`endif
    return sh[31:0];
  endfunction

  // compare process: outputs vs model every cycle, then advance the model
  always @(negedge aclk) begin
    bit exp_v;
    bit exp_rdy;
    exp_v   = (exp_q.size() > 0);
    exp_rdy = !((blk_n == N-1) && exp_v && !tready_out);
    if (live) begin
      chk("tvalid_out", {31'd0, tvalid_out}, {31'd0, exp_v});
      if (exp_v) chk("tdata_out", tdata_out, exp_q[0]);
      chk("tready_in", {31'd0, tready_in}, {31'd0, exp_rdy});
    end
    if (!aresetn) begin
      blk_n   = 0;
      blk_sum = 0;
      exp_q.delete();
      live    = 1'b1;
    end else if (live) begin
      if (exp_v && tready_out) begin
        obs_q.push_back(tdata_out);
        void'(exp_q.pop_front());
      end
      if (tvalid_in && exp_rdy) begin
        blk_sum += longint'($signed(tdata_in));
        blk_n++;
        if (blk_n == N) begin
          exp_q.push_back(ref_scale(blk_sum));
          blk_n   = 0;
          blk_sum = 0;
        end
      end
    end
  end

  // present one sample and return just after the edge that accepts it
  task automatic send(input logic [31:0] d);
    bit done;
    done      = 1'b0;
    tvalid_in = 1'b1;
    tdata_in  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge aclk);
      done = tready_in;
      @(posedge aclk);
      #1;
    end
    chk("send_accept", {31'd0, done}, 32'd1);
  endtask

  initial begin
    int  c0;
    bit  acc;
    logic [31:0] exp_pos;
    logic [31:0] exp_neg;

    aresetn    = 1'b0;
    tvalid_in  = 1'b1;
    tdata_in   = 32'd5;
    tready_out = 1'b1;
    tvalid_in2 = 1'b0;
    tdata_in2  = 32'd0;

    // reset held with valid input asserted
    repeat (3) begin
      @(negedge aclk);
      chk("rst_tvalid", {31'd0, tvalid_out}, 32'd0);
      chk("rst_tdata", tdata_out, 32'd0);
      chk("rst_tready", {31'd0, tready_in}, 32'd1);
    end
    @(posedge aclk); #1;
    aresetn   = 1'b1;
    tvalid_in = 1'b0;
    @(posedge aclk); #1;

    // basic dump and back-to-back second block
    c0 = cyc;
    send(32'd4); send(32'd8); send(32'd12); send(32'd16);
    chk("basic_valid", {31'd0, tvalid_out}, 32'd1);
    chk("basic_data", tdata_out, 32'd10);
    send(32'd1); send(32'd1); send(32'd1); send(32'd1);
    chk("ones_data", tdata_out, 32'd1);
    chk("no_gap_cycles", cyc - c0, 32'd8);

    // negative rounding
    send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFF); send(32'hFFFF_FFFE);
    chk("neg_data", tdata_out, 32'hFFFF_FFFE);

    // backpressure
    send(32'd2); send(32'd2); send(32'd2); send(32'd2);
    chk("bp_first", tdata_out, 32'd2);
    tready_out = 1'b0;
    send(32'd4); send(32'd4); send(32'd4);
    repeat (4) begin
      @(negedge aclk);
      chk("bp_tready_low", {31'd0, tready_in}, 32'd0);
      chk("bp_hold_valid", {31'd0, tvalid_out}, 32'd1);
      chk("bp_hold_data", tdata_out, 32'd2);
    end
    @(posedge aclk); #1;
    tready_out = 1'b1;
    @(negedge aclk);
    chk("bp_tready_back", {31'd0, tready_in}, 32'd1);
    @(posedge aclk); #1;
    chk("bp_old_sent", obs_q[obs_q.size()-1], 32'd2);
    chk("bp_new_valid", {31'd0, tvalid_out}, 32'd1);
    chk("bp_new_data", tdata_out, 32'd4);
    send(32'd4); send(32'd4); send(32'd4); send(32'd4);
    chk("bp_after", tdata_out, 32'd4);

    // mid-block reset discards the partial sum
    send(32'd100); send(32'd100);
    tvalid_in = 1'b0;
    aresetn   = 1'b0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
    chk("midrst_valid", {31'd0, tvalid_out}, 32'd0);
    send(32'd1); send(32'd2); send(32'd3); send(32'd6);
    chk("midrst_data", tdata_out, 32'd3);

    // randomized traffic, checked by the compare process
    tvalid_in = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge aclk);
      acc = tvalid_in && tready_in;
      @(posedge aclk); #1;
      if (!tvalid_in || acc) begin
        tvalid_in = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 1) == 1) tdata_in = $urandom;
        else tdata_in = 32'($urandom_range(0, 64)) - 32'd32;
      end
      tready_out = ($urandom_range(0, 2) != 0);
    end
    tvalid_in  = 1'b0;
    tready_out = 1'b1;
    repeat (6) @(posedge aclk);
    #1;

    // 32-bit reduction corners on the N=2, SHIFT=0 instance
`ifdef SAXI_ID_SAT_EN
    exp_pos = 32'h7FFF_FFFF;
    exp_neg = 32'h8000_0000;
`else
    exp_pos = 32'hFFFF_FFFE;
    exp_neg = 32'h0000_0000;
`endif
    tvalid_in2 = 1'b1;
    tdata_in2  = 32'h7FFF_FFFF;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    tdata_in2 = 32'h8000_0000;
    chk("sat_pos_valid", {31'd0, tvalid_out2}, 32'd1);
    chk("sat_pos_data", tdata_out2, exp_pos);
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    tvalid_in2 = 1'b0;
    chk("sat_neg_valid", {31'd0, tvalid_out2}, 32'd1);
    chk("sat_neg_data", tdata_out2, exp_neg);
    chk("sat_tready", {31'd0, tready_in2}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
